// File: rtl/fir_seq_ctrl_if.sv
// ============================================================================
// Module      : fir_seq_ctrl_if
// Description : Sample, result and coefficient-configuration bundle for the
//               time-multiplexed FIR sequencer. The master modport is the
//               sample source / consumer / configuration side; the slave
//               modport is the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fir_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 3,
  parameter int ACC_W  = 18
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        out_data;
  logic                    cfg_we;
  logic [$clog2(TAPS)-1:0] cfg_addr;
  logic [COEF_W-1:0]       cfg_data;
  logic                    cfg_err;
  logic                    busy;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
// ============================================================================
// Module      : fir_seq_ctrl
// Description : Time-multiplexed FIR sequencer. Accepts one sample per
//               handshake into a TAPS-deep delay line, then performs one
//               multiply-accumulate per cycle against a runtime-loadable
//               coefficient file and presents the sum on a valid/ready port.
//               Optional macro FIR_SEQ_FLUSH_EN adds a synchronous flush input
//               that clears the delay line and discards any pending result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_seq_ctrl #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int TAPS     = 3,
  parameter int ACC_W    = 18,
  parameter int COEF_RST = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
`ifdef FIR_SEQ_FLUSH_EN
  input  wire logic          flush,
`endif
  fir_seq_ctrl_if.slave      bus
);

  localparam int c_addr_w = $clog2(TAPS);
  localparam int c_prod_w = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_x    [TAPS];
  logic [COEF_W-1:0]   r_coef [TAPS];
  logic [ACC_W-1:0]    r_acc;
  logic [c_addr_w-1:0] r_idx;
  logic [ACC_W-1:0]    r_out_data;
  logic                r_out_valid;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_cfg_err;

  logic                w_flush;
  logic                w_in_fire;
  logic                w_cfg_ok;
  logic                w_cfg_commit;
  logic                w_cfg_reject;
  logic [c_prod_w-1:0] w_prod;
  logic [ACC_W-1:0]    w_sum;

`ifdef FIR_SEQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // The registered ready is masked by flush so a flushed cycle never accepts.
  assign bus.in_ready  = r_in_ready & ~w_flush;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.busy      = r_busy;

  assign w_in_fire    = bus.in_valid & bus.in_ready;
  assign w_cfg_ok     = bus.cfg_we && (r_state == S_IDLE) && (int'(bus.cfg_addr) < TAPS);
  // Flush wins over a config write; such a write is silently dropped.
  assign w_cfg_commit = w_cfg_ok & ~w_flush;
  assign w_cfg_reject = bus.cfg_we & ~w_cfg_ok & ~w_flush;

  // Single shared multiplier; the sum wraps modulo 2^ACC_W.
  assign w_prod = c_prod_w'(r_x[r_idx]) * c_prod_w'(r_coef[r_idx]);
  assign w_sum  = r_acc + ACC_W'(w_prod);

  // Coefficient file and write-rejection pulse; untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= COEF_W'(COEF_RST);
      r_cfg_err <= 1'b0;
    end else begin
      if (w_cfg_commit) r_coef[bus.cfg_addr] <= bus.cfg_data;
      r_cfg_err <= w_cfg_reject;
    end
  end

  // Sequencer FSM: accept sample, walk all taps, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_flush) begin
      r_state     <= S_IDLE;
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            for (int k = TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
            r_x[0]     <= bus.in_data;
            r_acc      <= '0;
            r_idx      <= '0;
            r_state    <= S_MAC;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          r_idx <= r_idx + c_addr_w'(1);
          if (r_idx == c_addr_w'(TAPS - 1)) begin
            r_out_data  <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_seq_ctrl.sv
// ============================================================================
// Module      : tb_fir_seq_ctrl
// Description : Self-checking bench for fir_seq_ctrl with a direct-form
//               reference model (coefficient array + sample history).
//               The flush scenario is compiled in with FIR_SEQ_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_seq_ctrl;
  localparam int DATA_W   = 8;
  localparam int COEF_W   = 8;
  localparam int TAPS     = 3;
  localparam int ACC_W    = 18;
  localparam int COEF_RST = 1;

  logic clk;
  logic rst_n;
`ifdef FIR_SEQ_FLUSH_EN
  logic flush;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  longint unsigned m_coef [TAPS];
  longint unsigned m_x    [TAPS];

  fir_seq_ctrl_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W)) u_if ();

  fir_seq_ctrl #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W), .COEF_RST(COEF_RST)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef FIR_SEQ_FLUSH_EN
    .flush(flush),
`endif
    .bus  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_y();
    longint unsigned s = 0;
    for (int k = 0; k < TAPS; k++) s += m_coef[k] * m_x[k];
    return longint'(s % (64'd1 << ACC_W));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = COEF_RST;
      m_x[k]    = 0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (u_if.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_wait", longint'(u_if.in_ready), 1);
  endtask

  task automatic cfg_write(input int addr, input int data, input bit exp_err);
    u_if.cfg_we   = 1'b1;
    u_if.cfg_addr = 2'(addr);
    u_if.cfg_data = 8'(data);
    tick();
    u_if.cfg_we = 1'b0;
    chk("cfg_err", longint'(u_if.cfg_err), exp_err ? 1 : 0);
    if (!exp_err) m_coef[addr] = longint'(data);
  endtask

  // Send one sample, check latency and result, then consume after 'hold' stalls.
  task automatic send(input int d, input int hold, input bit inject, output longint got);
    longint exp;
    int     lat = 0;
    wait_ready();
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'(d);
    tick();
    u_if.in_valid = 1'b0;
    for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = longint'(d);
    exp = model_y();
    chk("busy_mac", longint'(u_if.busy), 1);
    if (inject) begin
      u_if.cfg_we   = 1'b1;
      u_if.cfg_addr = 2'd1;
      u_if.cfg_data = 8'd7;
    end
    while (lat < 20) begin
      tick();
      lat++;
      if (inject && lat == 1) begin
        chk("cfg_err_mac", longint'(u_if.cfg_err), 1);
        u_if.cfg_we = 1'b0;
      end
      if (inject && lat == 2) chk("cfg_err_clear", longint'(u_if.cfg_err), 0);
      if (u_if.out_valid === 1'b1) break;
    end
    chk("latency", lat, TAPS);
    chk("out_data", longint'(u_if.out_data), exp);
    got = longint'(u_if.out_data);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", longint'(u_if.out_valid), 1);
      chk("hold_data", longint'(u_if.out_data), exp);
      chk("hold_in_ready", longint'(u_if.in_ready), 0);
    end
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    chk("post_valid", longint'(u_if.out_valid), 0);
    chk("post_busy", longint'(u_if.busy), 0);
    chk("post_in_ready", longint'(u_if.in_ready), 1);
    chk("post_data_kept", longint'(u_if.out_data), exp);
  endtask

  initial begin
    longint got;
    rst_n          = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.out_ready = 1'b0;
    u_if.cfg_we    = 1'b0;
    u_if.cfg_addr  = '0;
    u_if.cfg_data  = '0;
`ifdef FIR_SEQ_FLUSH_EN
    flush = 1'b0;
`endif
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", longint'(u_if.in_ready), 0);
    chk("rst_out_valid", longint'(u_if.out_valid), 0);
    chk("rst_out_data", longint'(u_if.out_data), 0);
    chk("rst_cfg_err", longint'(u_if.cfg_err), 0);
    chk("rst_busy", longint'(u_if.busy), 0);
    rst_n = 1'b1;
    tick();

    // Coefficients {1,2,1}; samples 10,20,30 -> 10,40,80
    cfg_write(0, 1, 0);
    cfg_write(1, 2, 0);
    cfg_write(2, 1, 0);
    send(10, 0, 0, got); chk("t1_y0", got, 10);
    send(20, 0, 0, got); chk("t1_y1", got, 40);
    send(30, 0, 0, got); chk("t1_y2", got, 80);

    // Backpressure for 5 cycles
    send(40, 5, 0, got);

    // Rejected writes: during MAC and out-of-range address
    send(50, 0, 1, got);
    cfg_write(3, 9, 1);
    tick();
    chk("cfg_err_idle_clear", longint'(u_if.cfg_err), 0);
    send(0, 0, 0, got);

    // Full-scale: no wrap
    for (int k = 0; k < TAPS; k++) cfg_write(k, 255, 0);
    send(255, 0, 0, got);
    send(255, 0, 0, got);
    send(255, 0, 0, got); chk("t4_full_scale", got, 195075);

    // Randomised traffic against the model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) cfg_write($urandom_range(0, TAPS - 1), $urandom_range(0, 255), 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      send($urandom_range(0, 255), $urandom_range(0, 3), 0, got);
    end

    // Reset mid-MAC discards the sample in flight
    wait_ready();
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'd99;
    tick();
    u_if.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("amid_out_valid", longint'(u_if.out_valid), 0);
    chk("amid_busy", longint'(u_if.busy), 0);
    chk("amid_in_ready", longint'(u_if.in_ready), 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    send(5, 0, 0, got); chk("t5_after_reset", got, 5);

`ifdef FIR_SEQ_FLUSH_EN
    // Flush clears history; coefficients survive
    cfg_write(0, 1, 0);
    cfg_write(1, 2, 0);
    cfg_write(2, 1, 0);
    send(10, 0, 0, got);
    send(20, 0, 0, got);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", longint'(u_if.in_ready), 0);
    tick();
    flush = 1'b0;
    for (int k = 0; k < TAPS; k++) m_x[k] = 0;
    send(30, 0, 0, got); chk("t6_flush", got, 30);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
